// File: rtl/alu_defs.sv
// Shared definitions for the ALU arbiter: width, opcode map, FSM state encoding.
package alu_defs;

    localparam int W = 32;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_MOV = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    localparam logic [3:0] OPMAX = OP_SRA;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Only the shift ops produce a meaningful carry from the ALU.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves past the granted port on accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept && (gnt != 2'b00)) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/alu_arb.sv
// Shares one registered ALU between two requesters, one op in flight at a time.
// Optional build macro ALU_ARB_CMP_FIX_EN: CMP issued as SUB, result reduced to an equality flag.
module alu_arb
    import alu_defs::*;
#(
    parameter int         W     = alu_defs::W,
    parameter logic [3:0] OPMAX = alu_defs::OPMAX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [W-1:0] req0_tr,
    input  logic [W-1:0] req0_sr,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [W-1:0] req1_tr,
    input  logic [W-1:0] req1_sr,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_dr,
    output logic         rsp0_cf,
    output logic         rsp0_of,
    output logic         rsp0_err,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_dr,
    output logic         rsp1_cf,
    output logic         rsp1_of,
    output logic         rsp1_err,
    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_tr,
    output logic [W-1:0] alu_sr,
    input  logic [W-1:0] alu_dr,
    input  logic         alu_cf,
    input  logic         alu_of
);

    state_t       state, state_nx;
    logic [1:0]   gnt;
    logic         accept;
    logic         owner;
    logic [3:0]   op_q;
    logic [W-1:0] dr_q;
    logic         cf_q, of_q, err_q;
    logic [3:0]   sel_op;
    logic [W-1:0] sel_tr, sel_sr;
    logic         sel_legal;
    logic         rsp_hs;

    function automatic logic [3:0] issue_op(input logic [3:0] op);
`ifdef ALU_ARB_CMP_FIX_EN
        return (op == OP_CMP) ? OP_SUB : op;
`else
        return op;
`endif
    endfunction

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .accept (accept),
        .gnt    (gnt)
    );

    // Ready is masked by rst so nothing looks accepted while reset is held.
    assign accept     = (state == ST_IDLE) && !rst && (gnt != 2'b00);
    assign req0_ready = accept && gnt[0];
    assign req1_ready = accept && gnt[1];

    assign sel_op    = gnt[1] ? req1_op : req0_op;
    assign sel_tr    = gnt[1] ? req1_tr : req0_tr;
    assign sel_sr    = gnt[1] ? req1_sr : req0_sr;
    assign sel_legal = (sel_op <= OPMAX);

    assign rsp0_valid = (state == ST_RESP) && !owner;
    assign rsp1_valid = (state == ST_RESP) && owner;
    assign rsp_hs     = owner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

    assign rsp0_dr  = dr_q;
    assign rsp0_cf  = cf_q;
    assign rsp0_of  = of_q;
    assign rsp0_err = err_q;
    assign rsp1_dr  = dr_q;
    assign rsp1_cf  = cf_q;
    assign rsp1_of  = of_q;
    assign rsp1_err = err_q;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = sel_legal ? ST_ISSUE : ST_RESP;
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT:  state_nx = ST_RESP;
            ST_RESP:  if (rsp_hs) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            owner  <= 1'b0;
            op_q   <= 4'b0000;
            alu_op <= 4'b0000;
            alu_tr <= '0;
            alu_sr <= '0;
            dr_q   <= '0;
            cf_q   <= 1'b0;
            of_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                owner <= gnt[1];
                op_q  <= sel_op;
                // ALU operand registers only move for legal ops, so they read as ISSUE-stage drive.
                if (sel_legal) begin
                    alu_op <= issue_op(sel_op);
                    alu_tr <= sel_tr;
                    alu_sr <= sel_sr;
                end else begin
                    dr_q  <= '0;
                    cf_q  <= 1'b0;
                    of_q  <= 1'b0;
                    err_q <= 1'b1;
                end
            end
            if (state == ST_WAIT) begin
                dr_q  <= alu_dr;
                cf_q  <= is_shift(op_q) && alu_cf;
                of_q  <= alu_of;
                err_q <= 1'b0;
`ifdef ALU_ARB_CMP_FIX_EN
                if (op_q == OP_CMP) begin
                    dr_q <= {{(W-1){1'b0}}, (alu_dr == '0)};
                    cf_q <= 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// Directed-vector bench for alu_arb with a behavioural registered ALU model alongside.
module tb_alu_arb;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op = 4'h0, req1_op = 4'h0;
    logic [W-1:0] req0_tr = '0, req0_sr = '0, req1_tr = '0, req1_sr = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [W-1:0] rsp0_dr, rsp1_dr;
    logic         rsp0_cf, rsp0_of, rsp0_err, rsp1_cf, rsp1_of, rsp1_err;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_tr, alu_sr;
    logic [W-1:0] alu_dr = '0;
    logic         alu_cf = 1'b0;
    logic         alu_of = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_arb dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_tr(req0_tr), .req0_sr(req0_sr),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_tr(req1_tr), .req1_sr(req1_sr),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_dr(rsp0_dr),
        .rsp0_cf(rsp0_cf), .rsp0_of(rsp0_of), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_dr(rsp1_dr),
        .rsp1_cf(rsp1_cf), .rsp1_of(rsp1_of), .rsp1_err(rsp1_err),
        .alu_op(alu_op), .alu_tr(alu_tr), .alu_sr(alu_sr),
        .alu_dr(alu_dr), .alu_cf(alu_cf), .alu_of(alu_of)
    );

    // Registered ALU model; cf is only updated by shifts, otherwise it keeps a stale value.
    always @(posedge clk) begin
        logic [W-1:0] r;
        int sh;
        sh = int'(alu_sr[4:0]);
        r  = '0;
        case (alu_op)
            4'b0000: begin r = alu_tr + alu_sr; alu_of <= (alu_tr[31] == alu_sr[31]) && (r[31] != alu_tr[31]); end
            4'b0001, 4'b0010: begin r = alu_tr - alu_sr; alu_of <= (alu_tr[31] != alu_sr[31]) && (r[31] != alu_tr[31]); end
            4'b0011: begin r = alu_tr & alu_sr; alu_of <= 1'b0; end
            4'b0100: begin r = alu_tr | alu_sr; alu_of <= 1'b0; end
            4'b0101: begin r = alu_tr ^ alu_sr; alu_of <= 1'b0; end
            4'b0110: begin r = ~alu_tr; alu_of <= 1'b0; end
            4'b0111: begin r = alu_sr; alu_of <= 1'b0; end
            4'b1000: begin r = alu_tr << sh; alu_cf <= (sh == 0) ? 1'b0 : alu_tr[32-sh]; alu_of <= 1'b0; end
            4'b1001: begin r = alu_tr >> sh; alu_cf <= (sh == 0) ? 1'b0 : alu_tr[sh-1]; alu_of <= 1'b0; end
            4'b1010: begin r = W'($signed(alu_tr) >>> sh); alu_cf <= (sh == 0) ? 1'b0 : alu_tr[sh-1]; alu_of <= 1'b0; end
            default: begin r = '0; alu_of <= 1'b0; end
        endcase
        alu_dr <= r;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at/after a negedge; returns once some ready is seen (or budget expires).
    task automatic wait_grant(output int port, output int waited);
        waited = 0;
        #1;
        while (!(req0_ready || req1_ready) && waited < 10) begin
            @(negedge clk); #1;
            waited++;
        end
        port = req1_ready ? 1 : (req0_ready ? 0 : -1);
    endtask

    // Presents a request, completes the handshake, returns #1 after the accepting edge.
    task automatic send(input int port, input logic [3:0] op, input logic [31:0] tr,
                        input logic [31:0] sr, output int waited);
        int gp;
        if (port == 0) begin req0_valid = 1; req0_op = op; req0_tr = tr; req0_sr = sr; end
        else           begin req1_valid = 1; req1_op = op; req1_tr = tr; req1_sr = sr; end
        wait_grant(gp, waited);
        chk("grant_port", gp, port);
        @(posedge clk); #1;
        if (port == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    // Counts cycles from the handshake to rsp valid, checks payload, optionally stalls, then acks.
    task automatic wait_rsp(input int port, input logic [31:0] dr, input logic cf, input logic of,
                            input logic err, input int lat, input int stall);
        int  k = 0;
        logic got = 0, rdy_seen = 0, other = 0;
        while (!got && k < 10) begin
            @(negedge clk);
            k++;
            rdy_seen |= req0_ready | req1_ready;
            other    |= (port == 0) ? rsp1_valid : rsp0_valid;
            got = (port == 0) ? rsp0_valid : rsp1_valid;
        end
        chk("rsp_latency", k, lat);
        chk("no_ready_busy", rdy_seen, 0);
        chk("other_rsp_idle", other, 0);
        if (got) begin
            chk("rsp_dr",  (port == 0) ? rsp0_dr  : rsp1_dr,  dr);
            chk("rsp_cf",  (port == 0) ? rsp0_cf  : rsp1_cf,  cf);
            chk("rsp_of",  (port == 0) ? rsp0_of  : rsp1_of,  of);
            chk("rsp_err", (port == 0) ? rsp0_err : rsp1_err, err);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("stall_valid", (port == 0) ? rsp0_valid : rsp1_valid, 1);
                chk("stall_dr", (port == 0) ? rsp0_dr : rsp1_dr, dr);
                chk("stall_no_ready", req0_ready | req1_ready, 0);
            end
            if (port == 0) rsp0_ready = 1; else rsp1_ready = 1;
            @(negedge clk);
            rsp0_ready = 0; rsp1_ready = 0;
            chk("rsp_dropped", rsp0_valid | rsp1_valid, 0);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_req_ready", {req0_ready, req1_ready}, 0);
        chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        chk("rst_rsp_dr", rsp0_dr, 0);
        chk("rst_rsp_flags", {rsp0_cf, rsp0_of, rsp0_err}, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_tr", alu_tr, 0);
        chk("rst_alu_sr", alu_sr, 0);
    endtask

    typedef struct {
        int          port;
        logic [3:0]  op;
        logic [31:0] tr;
        logic [31:0] sr;
        logic [31:0] dr;
        logic        cf;
        logic        of;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int w, gp;
        logic [3:0] last_op;
        logic       spurious;

        vecs[0]  = '{0, 4'b0000, 32'd5,          32'd7,          32'd12,         0, 0, 0, 3};
        vecs[1]  = '{1, 4'b1000, 32'h8000_0001,  32'd1,          32'h0000_0002,  1, 0, 0, 3};
        vecs[2]  = '{1, 4'b0011, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'h0F0F_0000,  0, 0, 0, 3};
        vecs[3]  = '{0, 4'b0000, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  0, 1, 0, 3};
        vecs[4]  = '{0, 4'b0001, 32'd10,         32'd3,          32'd7,          0, 0, 0, 3};
        vecs[5]  = '{0, 4'b1100, 32'd5,          32'd6,          32'd0,          0, 0, 1, 1};
        vecs[6]  = '{1, 4'b1010, 32'h8000_0008,  32'd4,          32'hF800_0000,  1, 0, 0, 3};
        vecs[7]  = '{0, 4'b1001, 32'h0000_0010,  32'd33,         32'h0000_0008,  0, 0, 0, 3};
        vecs[8]  = '{1, 4'b0101, 32'hA5A5_A5A5,  32'hFFFF_0000,  32'h5A5A_A5A5,  0, 0, 0, 3};
        vecs[9]  = '{0, 4'b0100, 32'h0000_00F0,  32'h0000_0F00,  32'h0000_0FF0,  0, 0, 0, 3};
        vecs[10] = '{1, 4'b1111, 32'd1,          32'd2,          32'd0,          0, 0, 1, 1};
`ifdef ALU_ARB_CMP_FIX_EN
        vecs[11] = '{0, 4'b0010, 32'd9,          32'd9,          32'd1,          0, 0, 0, 3};
        vecs[12] = '{1, 4'b0010, 32'd9,          32'd4,          32'd0,          0, 0, 0, 3};
`else
        vecs[11] = '{0, 4'b0010, 32'd9,          32'd9,          32'd0,          0, 0, 0, 3};
        vecs[12] = '{1, 4'b0010, 32'd9,          32'd4,          32'd5,          0, 0, 0, 3};
`endif
        vecs[13] = '{1, 4'b0001, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  0, 1, 0, 3};

        // Reset state, with a request pending so ready masking is exercised.
        req1_valid = 1;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_state();
        req1_valid = 0;
        rst = 0;
        @(negedge clk);

        // Both valid from reset: grants go 0, 1, 0 with requesters re-requesting at once.
        req0_valid = 1; req0_op = 4'b0001; req0_tr = 32'd10; req0_sr = 32'd3;
        req1_valid = 1; req1_op = 4'b0001; req1_tr = 32'd10; req1_sr = 32'd3;
        for (int g = 0; g < 3; g++) begin
            wait_grant(gp, w);
            chk("rr_grant", gp, (g == 1) ? 1 : 0);
            chk("rr_single_ready", req0_ready & req1_ready, 0);
            @(posedge clk); #1;
            if (g == 2) begin req0_valid = 0; req1_valid = 0; end
            wait_rsp((gp == 1) ? 1 : 0, 32'd7, 0, 0, 0, 3, 0);
        end
        last_op = 4'b0001;

        for (int i = 0; i < 14; i++) begin
            send(vecs[i].port, vecs[i].op, vecs[i].tr, vecs[i].sr, w);
            chk("ready_immediate", w, 0);
            wait_rsp(vecs[i].port, vecs[i].dr, vecs[i].cf, vecs[i].of, vecs[i].err, vecs[i].lat, 0);
            if (vecs[i].err) begin
                chk("illegal_alu_op_held", alu_op, last_op);
            end else begin
`ifdef ALU_ARB_CMP_FIX_EN
                last_op = (vecs[i].op == 4'b0010) ? 4'b0001 : vecs[i].op;
`else
                last_op = vecs[i].op;
`endif
            end
        end

        // Response stalled 5 cycles while port 1 waits; port 1 is served afterwards.
        send(0, 4'b0000, 32'd1, 32'd2, w);
        req1_valid = 1; req1_op = 4'b0111; req1_tr = 32'd0; req1_sr = 32'h55;
        wait_rsp(0, 32'd3, 0, 0, 0, 3, 5);
        #1;
        chk("after_stall_ready1", req1_ready, 1);
        send(1, 4'b0111, 32'd0, 32'h55, w);
        wait_rsp(1, 32'h55, 0, 0, 0, 3, 0);

        // Reset asserted in WAIT: outputs clear at once, the op is never answered.
        send(0, 4'b0000, 32'd5, 32'd7, w);
        @(negedge clk);
        @(negedge clk);
        req1_valid = 1;
        rst = 1;
        #1;
        chk_reset_state();
        @(negedge clk);
        rst = 0;
        req1_valid = 0;
        spurious = 0;
        repeat (6) begin
            @(negedge clk);
            spurious |= rsp0_valid | rsp1_valid;
        end
        chk("no_rsp_after_reset", spurious, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_arb.md
Name: alu_arb

Overview:
- Shares the single registered 32-bit ALU between two requesters, e.g. the execute stage (port 0) and the address/branch unit (port 1).
- Arbitrates requests round-robin and drives the ALU op/tr/sr inputs for the ALU's one-cycle registered latency.
- Captures dr/cf/of and returns the result to the owning requester over a valid/ready response channel.
- One operation is in flight at a time.

Parameters:
- W, 32, operand/result width; must match the ALU.
- OPMAX, 4'b1010, highest legal opcode (SRA); codes above it are rejected.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- reqN_valid  in  1  request present (N = 0, 1)
- reqN_ready  out  1  request accepted this cycle
- reqN_op  in  4  ALU opcode
- reqN_tr  in  W  first operand
- reqN_sr  in  W  second operand / shift amount
- rspN_valid  out  1  response present
- rspN_ready  in  1  requester accepts response
- rspN_dr  out  W  result
- rspN_cf  out  1  carry-out (shift ops only)
- rspN_of  out  1  overflow flag
- rspN_err  out  1  illegal opcode
- alu_op  out  4  to ALU op
- alu_tr  out  W  to ALU tr
- alu_sr  out  W  to ALU sr
- alu_dr  in  W  from ALU dr
- alu_cf  in  1  from ALU cf
- alu_of  in  1  from ALU of

Behaviour:
- Reset (async, rst=1): state IDLE, rr pointer = port 0, owner = 0. All reqN_ready, rspN_valid, rspN_dr/cf/of/err = 0. alu_op = 4'b0000, alu_tr = alu_sr = 0.
- Reset mid-operation aborts the op. No response is ever issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the rr pointer's port.
  - reqN_ready = grantN, combinational from valid. At most one ready is high.
  - On handshake: latch owner, op, tr, sr; rr pointer moves to the other port.
  - Legal op -> ISSUE. Illegal op (>OPMAX) -> RESP with dr=0, cf=0, of=0, err=1. The ALU is untouched.
- ISSUE (1 cycle): alu_op/tr/sr driven from the latched registers. The ALU samples at the end of this cycle. -> WAIT.
- WAIT (1 cycle): alu_dr/cf/of are valid. Latch them into the response registers.
  - cf is forced to 0 unless op is SLL/SRL/SRA, because the ALU holds a stale cf for other ops.
  - err = 0. -> RESP.
- RESP: rsp<owner>_valid = 1, data held stable until rsp<owner>_ready. On handshake -> IDLE next cycle. No new request is accepted in RESP.
- Latency: request handshake in cycle T gives rsp_valid in cycle T+3. Minimum occupancy is 4 cycles per op.
- alu_op/tr/sr hold their last values outside ISSUE. ALU outputs are never sampled outside WAIT.
- Requests that drop valid without ready are ignored. The requester must hold op/tr/sr stable while valid && !ready.
- Shift amount is passed to the ALU unmodified; the ALU masks it to 5 bits.
- Never asserts both rsp valids. Never asserts ready in ISSUE/WAIT/RESP.

Optional Feature:
- Macro: ALU_ARB_CMP_FIX_EN.
- Defined:
  - op CMP (4'b0010) is issued to the ALU as SUB (4'b0001).
  - In WAIT: dr = (alu_dr == 0) ? 1 : 0, cf = 0, of = alu_of.
  - Response timing is unchanged.
- Undefined: CMP is forwarded as 4'b0010 and the ALU result is returned as-is.

Decomposition:
- Shared package alu_defs holds:
  - opcode constants OP_ADD..OP_SRA (4'b0000..4'b1010);
  - OPMAX;
  - FSM state encodings ST_IDLE/ST_ISSUE/ST_WAIT/ST_RESP (2 bits);
  - width W.
- Sub-module rr_arb2: 2-input round-robin grant with pointer update on accept.
  - Ports: clk, rst, req[1:0], accept, gnt[1:0].

Test Plan:
- Reset: rst high mid-WAIT -> all valids/ready 0 and alu_op 0 immediately. No response after rst falls.
- Port0 ADD tr=5, sr=7 accepted cycle T -> rsp0_valid at T+3, dr=12, cf=0, err=0. rsp1_valid stays 0.
- Both valid from reset, both SUB 10-3 -> port0 granted first, port1 granted at its next IDLE. Then port0 is re-requested -> port0 granted only after port1 (alternation).
- Port1 SLL tr=32'h8000_0001, sr=1 -> dr=32'h0000_0002, cf=1. Then port1 AND -> cf=0.
- Illegal op 4'b1100 on port0 -> response at T+1 with err=1, dr=0. alu_op unchanged.
- rsp0_ready held low 5 cycles -> rsp0 data stable, req1_ready 0 throughout. With ALU_ARB_CMP_FIX_EN, CMP 9,9 -> dr=1, CMP 9,4 -> dr=0.
